// File: rtl/mod_counter.sv
// mod_counter: modulo-(MAX_VAL+1) up/down counter with combinational carry-out for cascading.
// Parallel load (with clamp to MAX_VAL) exists only when MOD_COUNTER_LOAD_EN is defined.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic             load_act;
  logic [WIDTH-1:0] load_data;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

`ifdef MOD_COUNTER_LOAD_EN
  assign load_act  = load;
  assign load_data = (load_val > MAX_V) ? MAX_V : load_val;
`else
  // Ports kept for drop-in compatibility; their values never reach the counter.
  logic unused_load;
  assign unused_load = ^{load, load_val};
  assign load_act    = 1'b0;
  assign load_data   = '0;
`endif

  assign at_max    = (count == MAX_V);
  assign at_zero   = (count == '0);
  assign count_inc = at_max  ? '0    : count + WIDTH'(1);
  assign count_dec = at_zero ? MAX_V : count - WIDTH'(1);

  // Carry-out is suppressed whenever a higher-priority action overrides counting.
  assign tc = rst & ~clr & ~load_act & en & ((up & at_max) | (~up & at_zero));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load_act) begin
      count <= load_data;
    end else if (en) begin
      count <= up ? count_inc : count_dec;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: randomized and directed checks of mod_counter against an arithmetic model,
// plus a units/tens cascade (00..59). Honours MOD_COUNTER_LOAD_EN like the design.
module tb_mod_counter;

`ifdef MOD_COUNTER_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif
  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc;

  logic       c_en;
  logic [3:0] u_count;
  logic       u_tc;
  logic [2:0] t_count;
  logic       t_tc;

  int n_checks = 0;
  int n_pass   = 0;

  int m_count = 0;
  bit m_valid = 1'b0;
  int c_n     = 0;
  bit c_valid = 1'b0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MAX_VAL(9)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(count), .tc(tc)
  );

  mod_counter #(.WIDTH(4), .MAX_VAL(9)) u_units (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up(1'b1), .count(u_count), .tc(u_tc)
  );

  mod_counter #(.WIDTH(3), .MAX_VAL(5)) u_tens (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(3'd0),
    .en(u_tc), .up(1'b1), .count(t_count), .tc(t_tc)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: modulo arithmetic on the sampled inputs.
  always @(posedge clk) begin
    if (!rst) begin
      m_count = 0;
      m_valid = 1'b1;
    end else if (clr) begin
      m_count = 0;
    end else if (LOAD_ON && load) begin
      m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    end else if (en) begin
      m_count = up ? (m_count + 1) % (MAXV + 1) : (m_count + MAXV) % (MAXV + 1);
    end
    if (!rst) begin
      c_n     = 0;
      c_valid = 1'b1;
    end else if (c_en) begin
      c_n = (c_n + 1) % 60;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("count", int'(count), m_count);
      check("tc", int'(tc),
            int'(rst && !clr && !(LOAD_ON && load) && en &&
                 (up ? (m_count == MAXV) : (m_count == 0))));
    end
    if (c_valid) begin
      check("casc_units", int'(u_count), c_n % 10);
      check("casc_tens", int'(t_count), c_n / 10);
      check("casc_units_tc", int'(u_tc), int'(rst && c_en && (c_n % 10 == 9)));
      check("casc_tens_tc", int'(t_tc), int'(rst && c_en && (c_n == 59)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int up_seq[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    en = 1'b0; up = 1'b1; c_en = 1'b0;
    tick();

    // Up-wrap from reset
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("upwrap_count", int'(count), up_seq[i]);
      check("upwrap_tc", int'(tc), (up_seq[i] == 9) ? 1 : 0);
      tick();
    end

    // Direction change at the top boundary re-evaluates tc at once
    repeat (7) tick();
    @(negedge clk);
    check("dir_at9_count", int'(count), 9);
    check("dir_at9_tc_up", int'(tc), 1);
    up = 1'b0;
    #1;
    check("dir_at9_tc_down", int'(tc), 0);
    tick();
    @(negedge clk);
    check("dir_down_count", int'(count), 8);

    // Down-wrap from 0
    rst = 1'b0;
    tick();
    rst = 1'b1; en = 1'b1; up = 1'b0;
    @(negedge clk);
    check("downwrap_c0", int'(count), 0);
    check("downwrap_tc0", int'(tc), 1);
    tick();
    @(negedge clk);
    check("downwrap_c9", int'(count), 9);
    check("downwrap_tc9", int'(tc), 0);
    tick();
    @(negedge clk);
    check("downwrap_c8", int'(count), 8);
    tick();
    @(negedge clk);
    check("downwrap_c7", int'(count), 7);

    // Priority: reset beats everything, clear beats load
    rst = 1'b0; clr = 1'b1; load = 1'b1; load_val = 4'd6; en = 1'b1; up = 1'b1;
    #1;
    check("prio_rst_tc", int'(tc), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("prio_rst_count", int'(count), 0);
    check("prio_clr_tc", int'(tc), 0);
    tick();
    @(negedge clk);
    check("prio_clr_load_count", int'(count), 0);
    clr = 1'b0; load = 1'b0;

`ifdef MOD_COUNTER_LOAD_EN
    en = 1'b0; load = 1'b1; load_val = 4'd13;
    tick();
    @(negedge clk);
    check("load_clamp", int'(count), 9);
    en = 1'b1; load_val = 4'd4;
    tick();
    @(negedge clk);
    check("load_with_en", int'(count), 4);
    clr = 1'b1; load_val = 4'd7;
    tick();
    @(negedge clk);
    check("clr_and_load", int'(count), 0);
    clr = 1'b0; load = 1'b0;
`else
    en = 1'b1; up = 1'b1;
    tick();
    @(negedge clk);
    check("noload_pre", int'(count), 1);
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    tick();
    @(negedge clk);
    check("noload_hold", int'(count), 1);
    en = 1'b1;
    tick();
    @(negedge clk);
    check("noload_inc", int'(count), 2);
    load = 1'b0;
`endif

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      tick();
      rst      = ($urandom_range(0, 15) != 0);
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
    end

    // Cascade 00..59 and back to 00
    rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; c_en = 1'b0;
    tick();
    rst = 1'b1; c_en = 1'b1;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      if (i == 59) begin
        check("casc59_tens", int'(t_count), 5);
        check("casc59_units", int'(u_count), 9);
        check("casc59_tc", int'(t_tc), 1);
      end
      if (i == 60) begin
        check("casc00_tens", int'(t_count), 0);
        check("casc00_units", int'(u_count), 0);
      end
      tick();
    end
    c_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter register width in bits; legal range 1..16.
REQ-002 Parameter MAX_VAL, default 9, terminal value of the up-count; legal range 1..(2^WIDTH)-1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 Port clr, input, 1 bit: synchronous clear to 0.
REQ-006 Port load, input, 1 bit: synchronous parallel-load strobe.
REQ-007 Port load_val, input, WIDTH bits: value loaded when load is active.
REQ-008 Port en, input, 1 bit: count enable, also the carry-in from a lower cascaded stage.
REQ-009 Port up, input, 1 bit: direction select; 1 counts up, 0 counts down.
REQ-010 Port count, output, WIDTH bits: registered counter value.
REQ-011 Port tc, output, 1 bit: combinational terminal-count and carry-out to the next stage.

Function
REQ-012 count SHALL always lie in 0..MAX_VAL.
REQ-013 Per-edge priority SHALL be rst, then clr, then load, then en; with none active, count holds.
REQ-014 With en=1 and up=1, count SHALL increment by 1, and the edge after count==MAX_VAL SHALL yield 0.
REQ-015 With en=1 and up=0, count SHALL decrement by 1, and the edge after count==0 SHALL yield MAX_VAL.
REQ-016 tc SHALL equal en AND ((up AND count==MAX_VAL) OR (NOT up AND count==0)); it is purely combinational with no register stage.
REQ-017 tc SHALL be 0 while rst=0, clr=1 or load=1.
REQ-018 Update latency SHALL be one clock: count reflects clr, load or en on the edge at which they are sampled.
REQ-019 A direction change SHALL take effect on the same edge it is sampled, with no idle cycle; up toggling while at a boundary re-evaluates tc immediately.
REQ-020 load_val greater than MAX_VAL SHALL be clamped, loading MAX_VAL.
REQ-021 Simultaneous load and en SHALL load load_val with no increment applied.
REQ-022 Simultaneous clr and load SHALL give 0.
REQ-023 Cascading rule: stage N+1 en = stage N tc. A chain of MAX_VAL=9 stages SHALL form a BCD counter; MAX_VAL=5 above a MAX_VAL=9 stage SHALL form 00..59.
REQ-024 Arithmetic SHALL be unsigned at WIDTH bits; no intermediate value wider than WIDTH+1 bits is required.

Reset
REQ-025 rst=0 at a rising edge SHALL set count=0 regardless of all other inputs.
REQ-026 Reset asserted mid-count SHALL take effect at the next edge; count resumes from 0 on the first edge with rst=1.
REQ-027 tc SHALL read 0 during reset.
REQ-028 There is no asynchronous path from rst to count.

Configuration
REQ-029 Macro MOD_COUNTER_LOAD_EN SHALL control the parallel-load feature.
REQ-030 With MOD_COUNTER_LOAD_EN defined, load and load_val SHALL behave per REQ-013, REQ-020, REQ-021 and REQ-022.
REQ-031 With MOD_COUNTER_LOAD_EN undefined, the load and load_val ports SHALL remain present but be ignored, treated as load=0; no clamp logic is synthesised.

Verification
REQ-032 Up-wrap: WIDTH=4, MAX_VAL=9, up=1, en=1 for 12 cycles from reset -> count 0,1..9,0,1; tc=1 only while count=9.
REQ-033 Down-wrap: up=0, en=1 from count=0 -> next 9,8,7; tc=1 in the cycle count=0.
REQ-034 Load clamp: load=1, load_val=13, MAX_VAL=9 -> count=9; load=1 with en=1, load_val=4 -> count=4, not 5.
REQ-035 Priority: rst=0 with clr=1, load=1, en=1 -> count=0; then rst=1, clr=1, load=1 -> count=0, tc=0.
REQ-036 Cascade: MAX_VAL=9 units stage feeding a MAX_VAL=5 tens stage, 60 enabled cycles from 00 -> 59 reached then 00; tens tc=1 only at 59.
REQ-037 Macro off: load=1, load_val=7, en=0 -> count unchanged; with en=1, normal increment occurs.
